// File: rtl/mherloa_pkg.sv
// mherloa_pkg: shared FSM state type and default widths for the approximate accumulator.
package mherloa_pkg;
   localparam int DEF_ADDER_LENGTH   = 16;
   localparam int DEF_IMPRECISE_PART = 8;
   localparam int DEF_COUNT_WIDTH    = 8;
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
endpackage

// File: rtl/mherloa_adder.sv
// mherloa_adder: HERLOA-style approximate adder, exact upper part and cheap low part.
module mherloa_adder #(
   parameter int ADDER_LENGTH   = mherloa_pkg::DEF_ADDER_LENGTH,
   parameter int IMPRECISE_PART = mherloa_pkg::DEF_IMPRECISE_PART
) (
   input  logic [ADDER_LENGTH-1:0] a,
   input  logic [ADDER_LENGTH-1:0] b,
   output logic [ADDER_LENGTH:0]   s
);
   localparam int K = IMPRECISE_PART;
   localparam int U = ADDER_LENGTH - K;
   logic p, g;
   assign p = a[K-1] ^ b[K-1];
   assign g = a[K-2] & b[K-2];
   assign s[K-5:0] = '1;
   assign s[K-4] = a[K-4] | b[K-4] | (p & g);
   assign s[K-3] = a[K-3] | b[K-3] | (p & g);
   assign s[K-2] = (a[K-2] | b[K-2]) & ~(g & ~p);
   assign s[K-1] = p | g;
   assign s[ADDER_LENGTH:K] = {1'b0, a[ADDER_LENGTH-1:K]} + {1'b0, b[ADDER_LENGTH-1:K]}
                            + {{U{1'b0}}, a[K-1] & b[K-1]};
endmodule

// File: rtl/mherloa_accumulator.sv
// mherloa_accumulator: sums a packet of beats with the approximate adder and holds the
// saturating result, overflow flag and beat count until the consumer takes it.
module mherloa_accumulator
   import mherloa_pkg::*;
#(
   parameter int ADDER_LENGTH   = DEF_ADDER_LENGTH,
   parameter int IMPRECISE_PART = DEF_IMPRECISE_PART,
   parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDER_LENGTH-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ADDER_LENGTH-1:0] out_data,
   output logic                    out_overflow,
   output logic [COUNT_WIDTH-1:0]  out_count
);
   state_e                  state_q;
   logic [ADDER_LENGTH-1:0] acc_q, acc_d;
   logic                    ovf_q, ovf_d;
   logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [ADDER_LENGTH:0]   sum;
   mherloa_adder #(
      .ADDER_LENGTH  (ADDER_LENGTH),
      .IMPRECISE_PART(IMPRECISE_PART)
   ) u_adder (
      .a(acc_q),
      .b(in_data),
      .s(sum)
   );
   // first beat of a packet loads exactly; later beats accumulate with saturation
   always_comb begin
      acc_d = (state_q == IDLE) ? in_data : (sum[ADDER_LENGTH] ? '1 : sum[ADDER_LENGTH-1:0]);
      ovf_d = (state_q == IDLE) ? 1'b0 : (ovf_q | sum[ADDER_LENGTH]);
      cnt_d = (state_q == IDLE) ? COUNT_WIDTH'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (state_q == HOLD) begin
         if (out_ready) state_q <= IDLE;
      end else if (in_valid) begin
         state_q <= in_last ? HOLD : ACCUM;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end
   assign in_ready     = (state_q != HOLD);
   assign out_valid    = (state_q == HOLD);
   assign out_data     = acc_q;
   assign out_overflow = ovf_q;
   assign out_count    = cnt_q;
endmodule

// File: doc/mherloa_accumulator.md
MHERLOA_ACCUMULATOR -- requirements
Module: mherloa_accumulator

Interface
REQ-001 SHALL have parameter ADDER_LENGTH, default 16, which is the operand and accumulator width.
REQ-002 SHALL have parameter IMPRECISE_PART, default 8, which is the number of approximate low bits; legal range 5..ADDER_LENGTH-1.
REQ-003 SHALL have parameter COUNT_WIDTH, default 8, which is the width of the beat counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand beat is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-008 SHALL have port in_data, input, ADDER_LENGTH bits: the unsigned operand.
REQ-009 SHALL have port in_last, input, 1 bit: this beat is the final beat of the packet.
REQ-010 SHALL have port out_valid, output, 1 bit: a result is held.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port out_data, output, ADDER_LENGTH bits: the accumulated packet sum.
REQ-013 SHALL have port out_overflow, output, 1 bit: the packet saturated.
REQ-014 SHALL have port out_count, output, COUNT_WIDTH bits: the number of beats in the packet, saturating.

Function
REQ-015 SHALL define approx_add(x,y), with k=IMPRECISE_PART: s[k-5:0] all ones; p=x[k-1]^y[k-1]; g=x[k-2]&y[k-2].
REQ-016 SHALL compute s[k-4]=x|y|(p&g) and s[k-3]=x|y|(p&g), each taken at its own bit.
REQ-017 SHALL compute s[k-2]=(x[k-2]|y[k-2])&~(g&~p) and s[k-1]=p|g.
REQ-018 SHALL compute s[ADDER_LENGTH:k] as the exact sum of the upper bits with carry-in x[k-1]&y[k-1], giving an (ADDER_LENGTH+1)-bit result.
REQ-019 SHALL implement a state machine with states IDLE, ACCUM and HOLD; reset enters IDLE.
REQ-020 SHALL drive in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD; a beat is accepted when in_valid&in_ready.
REQ-021 SHALL, on an accepted beat in IDLE, load acc=in_data exactly with no addition, set count=1 and clear ovf.
REQ-022 SHALL, on an accepted beat in ACCUM, set acc=approx_add(acc,in_data)[ADDER_LENGTH-1:0], or all ones with ovf set if bit ADDER_LENGTH is 1; count increments and saturates at all ones.
REQ-023 SHALL keep ovf sticky, once set, until the next packet loads.
REQ-024 SHALL transition IDLE->ACCUM on an accepted beat without in_last, and ACCUM stays in ACCUM on such beats.
REQ-025 SHALL transition to HOLD on an accepted beat with in_last, from either IDLE or ACCUM, with acc, ovf and count updated by that beat.
REQ-026 SHALL assert out_valid exactly when in HOLD, so the latency is 1 cycle from the in_last beat to out_valid.
REQ-027 SHALL drive out_data=acc, out_overflow=ovf and out_count=count, all stable while out_valid=1 and out_ready=0.
REQ-028 SHALL transition HOLD->IDLE when out_ready=1; the next beat is accepted no earlier than the following cycle, and no same-cycle pass-through exists.
REQ-029 SHALL leave the state unchanged in any cycle with no accepted beat; idle gaps mid-packet are allowed.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, set state=IDLE, acc=0, ovf=0 and count=0, so that out_valid=0, out_data=0, out_overflow=0 and out_count=0.
REQ-031 SHALL drive in_ready=1 from the first cycle after reset.
REQ-032 SHALL give rst priority over all handshakes; a partial packet or an unconsumed result is discarded with no output.

Structure
REQ-033 SHALL place the state enum and the default width constants in shared package mherloa_pkg.
REQ-034 SHALL instantiate the approximate adder datapath as the existing combinational sub-module mherloa_adder, with a=acc and b=in_data; no other sub-modules are used.

Verification
REQ-035 SHALL check, with ADDER_LENGTH=16 and IMPRECISE_PART=8: a single beat 0x1234 with last -> next cycle out_valid=1, out_data=0x1234, count=1, overflow=0.
REQ-036 SHALL check the beats 0x0000, 0x0000(last) -> out_data=0x000F, count=2.
REQ-037 SHALL check the beats 0x0100, 0x0200(last) -> out_data=0x030F, and the beats 0x0080, 0x0080(last) -> out_data=0x010F.
REQ-038 SHALL check the beats 0xFF00, 0x0100, 0x0000(last) -> out_data=0xFFFF, out_overflow=1, count=3.
REQ-039 SHALL check that holding out_ready=0 for 5 cycles with in_valid=1 keeps in_ready=0 and the output stable; releasing out_ready gives IDLE, and the held beat is accepted the next cycle.
REQ-040 SHALL check that rst=1 after 2 of 3 beats returns all outputs to 0 with no out_valid, and that a following 1-beat packet 0x0005 gives out_data=0x0005.
